wb_select_arbiter: RTL and testbench

Parametrised, registered N:1 selector for the 18-bit datapath, replacing fixed combinational source multiplexers on the register-file write-back path (ALU result, RAM read data, immediate, etc.). Each source channel presents data under a valid/ready handshake. The block picks one channel per cycle, either by explicit select (legacy mux mode) or by round-robin arbitration. The chosen word is captured in a one-entry output register with its source index.

---
 rtl/wb_select_arbiter_if.sv | 26 ++
 rtl/wb_select_arbiter.sv | 116 +++++++++++
 tb/tb_wb_select_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_select_arbiter_if.sv
// rtl/wb_select_arbiter_if.sv - channel and output handshake bundle for wb_select_arbiter
interface wb_select_arbiter_if #(
    parameter int WIDTH    = 18,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
);
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_src;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/wb_select_arbiter.sv
// rtl/wb_select_arbiter.sv - registered N:1 write-back selector, direct or round-robin
// Optional transfer counter: WB_SELECT_GRANT_CNT_EN
module wb_select_arbiter #(
    parameter int WIDTH    = 18,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic clk,
    input  logic rst_n,
    wb_select_arbiter_if.slave bus
`ifdef WB_SELECT_GRANT_CNT_EN
    ,
    input  logic        cnt_clr,
    output logic [15:0] grant_cnt
`endif
);
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_src_q, out_src_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic                load_ok;
    logic                found;
    logic                xfer;
    logic [CHANNELS-1:0] grant;
    logic [CHANNELS-1:0] ready;
    logic [SEL_W-1:0]    grant_idx;
    logic [SEL_W-1:0]    idx;

    always_comb begin
        load_ok   = !out_valid_q || bus.out_ready;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        if (!bus.mode) begin
            // Out-of-range select values match no channel and so grant nothing.
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.sel == SEL_W'(i)) begin
                    grant[i]  = bus.in_valid[i];
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                idx = SEL_W'((int'(rr_ptr_q) + k) % CHANNELS);
                if (!found && bus.in_valid[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                end
            end
        end
    end

    always_comb begin
        ready       = rst_n ? (grant & {CHANNELS{load_ok}}) : '0;
        xfer        = |(ready & bus.in_valid);
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = bus.in_data[grant_idx*WIDTH +: WIDTH];
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
            if (bus.mode) begin
                rr_ptr_d = grant_idx;
            end
        end else if (load_ok) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SEL_W'(CHANNELS - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;

`ifdef WB_SELECT_GRANT_CNT_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (cnt_clr) begin
            grant_cnt_d = '0;
        end else if (xfer && grant_cnt_q != 16'hFFFF) begin
            grant_cnt_d = grant_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif
endmodule

// File: tb/tb_wb_select_arbiter.sv
// tb/tb_wb_select_arbiter.sv - directed self-checking bench for wb_select_arbiter
module tb_wb_select_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wb_select_arbiter_if #(.WIDTH(18), .CHANNELS(4)) bus ();
    wb_select_arbiter_if #(.WIDTH(18), .CHANNELS(3)) b3 ();

`ifdef WB_SELECT_GRANT_CNT_EN
    logic        cnt_clr, cnt_clr3;
    logic [15:0] grant_cnt, grant_cnt3;
`endif

    wb_select_arbiter #(.WIDTH(18), .CHANNELS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef WB_SELECT_GRANT_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    wb_select_arbiter #(.WIDTH(18), .CHANNELS(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3.slave)
`ifdef WB_SELECT_GRANT_CNT_EN
        ,
        .cnt_clr   (cnt_clr3),
        .grant_cnt (grant_cnt3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [17:0] chd [4];
    logic [3:0]  oh;

    initial begin
        chd[0] = 18'h00011;
        chd[1] = 18'h10022;
        chd[2] = 18'h2A5A5;
        chd[3] = 18'h3FFFF;
        rst_n         = 1'b0;
        bus.mode      = 1'b0;
        bus.sel       = 2'd0;
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b1;
        bus.in_data   = {chd[3], chd[2], chd[1], chd[0]};
        b3.mode       = 1'b0;
        b3.sel        = 2'd0;
        b3.in_valid   = 3'b000;
        b3.out_ready  = 1'b1;
        b3.in_data    = {18'h3C3C3, 18'h05555, 18'h12345};
`ifdef WB_SELECT_GRANT_CNT_EN
        cnt_clr  = 1'b0;
        cnt_clr3 = 1'b0;
`endif
        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_src",   32'(bus.out_src),   32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);

        rst_n   = 1'b1;
        bus.sel = 2'd2;
        #1;
        check("m0_sel2_ready", 32'(bus.in_ready), 32'h4);
        tick();
        check("m0_sel2_data",  32'(bus.out_data),  32'h2A5A5);
        check("m0_sel2_src",   32'(bus.out_src),   32'd2);
        check("m0_sel2_valid", 32'(bus.out_valid), 32'd1);

        bus.mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            oh = 4'b0001 << (k % 4);
            check("rr_ready", 32'(bus.in_ready), 32'(oh));
            tick();
            check("rr_src",   32'(bus.out_src),   32'(k % 4));
            check("rr_data",  32'(bus.out_data),  32'(chd[k % 4]));
            check("rr_valid", 32'(bus.out_valid), 32'd1);
        end

        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_ready", 32'(bus.in_ready),  32'd0);
            tick();
            check("stall_data",  32'(bus.out_data),  32'h3FFFF);
            check("stall_src",   32'(bus.out_src),   32'd3);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("unstall_ready", 32'(bus.in_ready), 32'h2);
        tick();
        check("unstall_data", 32'(bus.out_data), 32'h10022);
        check("unstall_src",  32'(bus.out_src),  32'd1);
        bus.in_valid = 4'hF;
        #1;
        check("rr_after_ch1", 32'(bus.in_ready), 32'h4);
        bus.in_valid = 4'h0;
        tick();
        check("drain_valid", 32'(bus.out_valid), 32'd0);
        check("drain_data",  32'(bus.out_data),  32'h10022);
        check("drain_src",   32'(bus.out_src),   32'd1);

        bus.mode     = 1'b0;
        bus.sel      = 2'd0;
        bus.in_valid = 4'b0001;
        #1;
        check("m0_sel0_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check("m0_sel0_data", 32'(bus.out_data), 32'h00011);
        check("m0_sel0_src",  32'(bus.out_src),  32'd0);
        bus.mode     = 1'b1;
        bus.in_valid = 4'hF;
        #1;
        check("m0_keeps_ptr", 32'(bus.in_ready), 32'h4);

        bus.out_ready = 1'b0;
        bus.mode      = 1'b0;
        bus.sel       = 2'd3;
        #1;
        check("hold_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("hold_data",  32'(bus.out_data),  32'h00011);
        check("hold_src",   32'(bus.out_src),   32'd0);
        check("hold_valid", 32'(bus.out_valid), 32'd1);

        bus.out_ready = 1'b1;
        tick();
        check("load3_data", 32'(bus.out_data), 32'h3FFFF);
        bus.out_ready = 1'b0;
        tick();
        check("load3_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_data",  32'(bus.out_data),  32'd0);
        check("rst_mid_src",   32'(bus.out_src),   32'd0);
        rst_n         = 1'b1;
        bus.mode      = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("rst_rr_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check("rst_rr_src",  32'(bus.out_src),  32'd0);
        check("rst_rr_data", 32'(bus.out_data), 32'h00011);

        b3.in_valid = 3'b111;
        #1;
        check("c3_sel0_ready", 32'(b3.in_ready), 32'h1);
        tick();
        check("c3_sel0_valid", 32'(b3.out_valid), 32'd1);
        check("c3_sel0_data",  32'(b3.out_data),  32'h12345);
        b3.sel = 2'd3;
        #1;
        check("c3_sel3_ready", 32'(b3.in_ready), 32'd0);
        tick();
        check("c3_sel3_valid", 32'(b3.out_valid), 32'd0);
        check("c3_sel3_data",  32'(b3.out_data),  32'h12345);
        b3.mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("c3_rr_src", 32'(b3.out_src), 32'(k % 3));
        end

`ifdef WB_SELECT_GRANT_CNT_EN
        bus.in_valid = 4'hF;
        cnt_clr      = 1'b1;
        tick();
        check("cnt_clr0", 32'(grant_cnt), 32'd0);
        cnt_clr = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("cnt_three", 32'(grant_cnt), 32'd3);
        for (int k = 0; k < 70000; k++) tick();
        check("cnt_sat", 32'(grant_cnt), 32'hFFFF);
        cnt_clr = 1'b1;
        tick();
        check("cnt_clr_xfer", 32'(grant_cnt), 32'd0);
        cnt_clr = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
